// File: rtl/nco_multichannel.sv
// nco_multichannel
//   Multi-channel quarter-wave LUT numerically controlled oscillator.
//   Each channel owns a signed phase step, an unsigned phase offset and a
//   phase accumulator; all channels share one elaboration-time sine ROM.
//   Three-stage pipeline: phase add + quadrant fold, ROM read, sign apply.
//
// Ports
//   iclk     clock, rising edge
//   iresetn  synchronous active-low reset
//   inCS     active-low run enable (high stalls accumulators and pipeline)
//   iwe      config write strobe (accepted regardless of inCS)
//   iwaddr   channel selected by a config write
//   istep    signed phase step (two's complement)
//   iphase   unsigned phase offset
//   isync    clears every phase accumulator
//   osin     packed signed sines, channel c at [c*LUT_WIDTH +: LUT_WIDTH]
//   ocos     packed signed cosines, same packing
//   ovalid   pipeline filled, outputs meaningful
module nco_multichannel #(
  parameter int LUT_WIDTH  = 16,
  parameter int LUT_LENGTH = 6,
  parameter int PHASE_FRAC = 4,
  parameter int CHANNELS   = 4,
  localparam int ACC_SIZE  = LUT_LENGTH + PHASE_FRAC,
  localparam int CH_BITS   = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                            iclk,
  input  logic                            iresetn,
  input  logic                            inCS,
  input  logic                            iwe,
  input  logic [CH_BITS-1:0]              iwaddr,
  input  logic [ACC_SIZE-1:0]             istep,
  input  logic [ACC_SIZE-1:0]             iphase,
  input  logic                            isync,
  output logic [CHANNELS*LUT_WIDTH-1:0]   osin,
  output logic [CHANNELS*LUT_WIDTH-1:0]   ocos,
  output logic                            ovalid
);

  localparam int M     = 1 << LUT_LENGTH;
  localparam int QW    = M / 4;
  // Folded index spans 0..M/4 inclusive, so it needs one bit more than k's low bits.
  localparam int IDX_W = LUT_LENGTH - 1;

  // Elaboration-time sine via Taylor series; first-quadrant values are
  // non-negative, so +0.5 then truncation is round-to-nearest.
  function automatic logic signed [LUT_WIDTH-1:0] rom_entry(input int j);
    real x, term, s, amp;
    x    = 2.0 * 3.14159265358979323846 * real'(j) / real'(M);
    term = x;
    s    = x;
    for (int n = 1; n < 14; n++) begin
      term = -term * x * x / real'((2 * n) * (2 * n + 1));
      s    = s + term;
    end
    amp = real'((1 << (LUT_WIDTH - 1)) - 1);
    return LUT_WIDTH'($rtoi(amp * s + 0.5));
  endfunction

  // Returns {negate, rom_index} for a full-period index k.
  function automatic logic [IDX_W:0] fold(input logic [LUT_LENGTH-1:0] k);
    logic [1:0]            q;
    logic [LUT_LENGTH-3:0] i;
    logic [IDX_W-1:0]      idx;
    q   = k[LUT_LENGTH-1 -: 2];
    i   = k[LUT_LENGTH-3:0];
    idx = q[0] ? (IDX_W'(QW) - IDX_W'(i)) : IDX_W'(i);
    return {q[1], idx};
  endfunction

  logic signed [LUT_WIDTH-1:0] rom [0:QW];

  for (genvar j = 0; j <= QW; j++) begin : g_rom
    localparam logic signed [LUT_WIDTH-1:0] VAL = rom_entry(j);
    assign rom[j] = VAL;
  end

  logic [ACC_SIZE-1:0]         step_r   [CHANNELS];
  logic [ACC_SIZE-1:0]         phase_r  [CHANNELS];
  logic [ACC_SIZE-1:0]         acc      [CHANNELS];
  logic [LUT_LENGTH-1:0]       k_sin    [CHANNELS];
  logic [LUT_LENGTH-1:0]       k_cos    [CHANNELS];
  logic [IDX_W:0]              f_sin    [CHANNELS];
  logic [IDX_W:0]              f_cos    [CHANNELS];
  logic [IDX_W-1:0]            sin_idx1 [CHANNELS];
  logic [IDX_W-1:0]            cos_idx1 [CHANNELS];
  logic                        sin_neg1 [CHANNELS];
  logic                        cos_neg1 [CHANNELS];
  logic signed [LUT_WIDTH-1:0] sin_mag2 [CHANNELS];
  logic signed [LUT_WIDTH-1:0] cos_mag2 [CHANNELS];
  logic                        sin_neg2 [CHANNELS];
  logic                        cos_neg2 [CHANNELS];
  logic [1:0]                  fill;

  always_comb begin
    for (int c = 0; c < CHANNELS; c++) begin
      // Fractional phase bits are dropped by the shift (truncation, no rounding).
      k_sin[c] = LUT_LENGTH'((acc[c] + phase_r[c]) >> PHASE_FRAC);
      k_cos[c] = k_sin[c] + LUT_LENGTH'(QW);
      f_sin[c] = fold(k_sin[c]);
      f_cos[c] = fold(k_cos[c]);
    end
  end

  always_ff @(posedge iclk) begin
    if (!iresetn) begin
      for (int c = 0; c < CHANNELS; c++) begin
        step_r[c]   <= '0;
        phase_r[c]  <= '0;
        acc[c]      <= '0;
        sin_idx1[c] <= '0;
        cos_idx1[c] <= '0;
        sin_neg1[c] <= 1'b0;
        cos_neg1[c] <= 1'b0;
        sin_mag2[c] <= '0;
        cos_mag2[c] <= '0;
        sin_neg2[c] <= 1'b0;
        cos_neg2[c] <= 1'b0;
      end
      osin <= '0;
      ocos <= '0;
      fill <= 2'd0;
    end else begin
      for (int c = 0; c < CHANNELS; c++) begin
        // Out-of-range addresses never match a channel, so they are ignored.
        if (iwe && (int'(iwaddr) == c)) begin
          step_r[c]  <= istep;
          phase_r[c] <= iphase;
        end

        if (isync)
          acc[c] <= '0;
        else if (!inCS)
          acc[c] <= acc[c] + step_r[c];

        if (!inCS) begin
          sin_idx1[c] <= f_sin[c][IDX_W-1:0];
          sin_neg1[c] <= f_sin[c][IDX_W];
          cos_idx1[c] <= f_cos[c][IDX_W-1:0];
          cos_neg1[c] <= f_cos[c][IDX_W];

          sin_mag2[c] <= rom[sin_idx1[c]];
          cos_mag2[c] <= rom[cos_idx1[c]];
          sin_neg2[c] <= sin_neg1[c];
          cos_neg2[c] <= cos_neg1[c];

          // ROM holds symmetric +/-A, so negation never overflows.
          osin[c*LUT_WIDTH +: LUT_WIDTH] <= sin_neg2[c] ? -sin_mag2[c] : sin_mag2[c];
          ocos[c*LUT_WIDTH +: LUT_WIDTH] <= cos_neg2[c] ? -cos_mag2[c] : cos_mag2[c];
        end
      end

      if (!inCS && (fill != 2'd3))
        fill <= fill + 2'd1;
    end
  end

  assign ovalid = (fill == 2'd3);

endmodule
